// File: rtl/draw_mouse_cursor.sv
// Final pixel stage: overlays a 16x16 arrow cursor on the VGA bus, 2-cycle delay.
// Optional blink when CURSOR_BLINK_EN is defined (BLINK_FRAMES per phase).
module draw_mouse_cursor #(
   parameter int          XPOS_MAX     = 799,
   parameter int          YPOS_MAX     = 599,
   parameter logic [11:0] CURSOR_COLOR = 12'hFFF,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] xpos_in,
   input  logic [11:0] ypos_in,
   input  logic [10:0] in_hcount,
   input  logic [10:0] in_vcount,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_hblnk,
   input  logic        in_vblnk,
   input  logic [11:0] in_rgb,
   output logic [10:0] out_hcount,
   output logic [10:0] out_vcount,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_hblnk,
   output logic        out_vblnk,
   output logic [11:0] out_rgb
);

   localparam logic [11:0] XL_MAX = 12'(XPOS_MAX - 15);
   localparam logic [11:0] YL_MAX = 12'(YPOS_MAX - 15);

   logic        r_vblnk_d;
   logic [11:0] r_xl, r_yl;
   logic        w_fe;
   logic [11:0] w_xclamp, w_yclamp;
   logic        w_hit;
   logic [3:0]  w_dx, w_dy;
   logic        w_visible;
   logic        w_pix;

   logic [10:0] r_hcount_s1, r_vcount_s1;
   logic        r_hsync_s1, r_vsync_s1, r_hblnk_s1, r_vblnk_s1;
   logic [11:0] r_rgb_s1;
   logic        r_hit_s1;
   logic [15:0] r_row_s1;
   logic [3:0]  r_dx_s1;

   // Row r of the arrow lights its r+1 leftmost pixels; rows 12..15 are empty.
   function automatic logic [15:0] rom_row(input logic [3:0] r);
      if (r < 4'd12) return 16'hFFFF << (4'd15 - r);
      else           return 16'h0000;
   endfunction

   // Frame edge, clamped position and cursor hit test.
   always_comb begin
      w_fe     = in_vblnk & ~r_vblnk_d;
      w_xclamp = (xpos_in > XL_MAX) ? XL_MAX : xpos_in;
      w_yclamp = (ypos_in > YL_MAX) ? YL_MAX : ypos_in;
      w_dx     = in_hcount[3:0] - r_xl[3:0];
      w_dy     = in_vcount[3:0] - r_yl[3:0];
      w_hit    = ({2'b00, in_hcount} >= {1'b0, r_xl}) &&
                 ({2'b00, in_hcount} <  {1'b0, r_xl} + 13'd16) &&
                 ({2'b00, in_vcount} >= {1'b0, r_yl}) &&
                 ({2'b00, in_vcount} <  {1'b0, r_yl} + 13'd16);
   end

   // Position is taken once per frame so the cursor never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vblnk_d <= 1'b0;
         r_xl      <= '0;
         r_yl      <= '0;
      end else begin
         r_vblnk_d <= in_vblnk;
         if (w_fe) begin
            r_xl <= w_xclamp;
            r_yl <= w_yclamp;
         end
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FCW-1:0] r_fc;
   logic           r_visible;

   // Blink phase counter; visibility only changes on a frame edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fc      <= '0;
         r_visible <= 1'b1;
      end else if (w_fe) begin
         if (r_fc == FCW'(BLINK_FRAMES - 1)) begin
            r_fc      <= '0;
            r_visible <= ~r_visible;
         end else begin
            r_fc <= r_fc + 1'b1;
         end
      end
   end

   assign w_visible = r_visible;
`else
   assign w_visible = 1'b1;
`endif

   // Stage 1: register the bus and look up the cursor row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcount_s1 <= '0;
         r_vcount_s1 <= '0;
         r_hsync_s1  <= 1'b0;
         r_vsync_s1  <= 1'b0;
         r_hblnk_s1  <= 1'b0;
         r_vblnk_s1  <= 1'b0;
         r_rgb_s1    <= '0;
         r_hit_s1    <= 1'b0;
         r_row_s1    <= '0;
         r_dx_s1     <= '0;
      end else begin
         r_hcount_s1 <= in_hcount;
         r_vcount_s1 <= in_vcount;
         r_hsync_s1  <= in_hsync;
         r_vsync_s1  <= in_vsync;
         r_hblnk_s1  <= in_hblnk;
         r_vblnk_s1  <= in_vblnk;
         r_rgb_s1    <= in_rgb;
         r_hit_s1    <= w_hit;
         r_row_s1    <= rom_row(w_dy);
         r_dx_s1     <= w_dx;
      end
   end

   assign w_pix = r_hit_s1 & r_row_s1[4'd15 - r_dx_s1] & w_visible &
                  ~r_hblnk_s1 & ~r_vblnk_s1;

   // Stage 2: composite and drive the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_hcount <= '0;
         out_vcount <= '0;
         out_hsync  <= 1'b0;
         out_vsync  <= 1'b0;
         out_hblnk  <= 1'b0;
         out_vblnk  <= 1'b0;
         out_rgb    <= '0;
      end else begin
         out_hcount <= r_hcount_s1;
         out_vcount <= r_vcount_s1;
         out_hsync  <= r_hsync_s1;
         out_vsync  <= r_vsync_s1;
         out_hblnk  <= r_hblnk_s1;
         out_vblnk  <= r_vblnk_s1;
         out_rgb    <= w_pix ? CURSOR_COLOR : r_rgb_s1;
      end
   end

endmodule

// File: doc/draw_mouse_cursor.md
# draw_mouse_cursor

Final pixel-pipeline stage of `top_vga`. It overlays a 16x16 arrow cursor on the incoming VGA timing and RGB bus at the mouse position, and drives the `vs`, `hs`, `r`, `g`, `b` outputs consumed by the board and by the tiff-capturing testbench. The mouse position is sampled once per frame, so the cursor never tears mid-frame. The block adds a fixed 2-cycle delay to the whole bus.

## Interface
Parameters:
- `XPOS_MAX`, 799, last visible column (800x600 @ 40 MHz, 1056x628 total).
- `YPOS_MAX`, 599, last visible line.
- `CURSOR_COLOR`, 12'hFFF, cursor RGB (4:4:4).
- `BLINK_FRAMES`, 30, frames per blink phase (used only with `CURSOR_BLINK_EN`).

Ports:
- `clk` in 1, 40 MHz pixel clock; sole clock.
- `rst_n` in 1, asynchronous active-low reset.
- `xpos_in` in 12, mouse X, already synchronous to `clk`.
- `ypos_in` in 12, mouse Y, already synchronous to `clk`.
- `in_hcount` in 11, `in_vcount` in 11, pixel coordinates.
- `in_hsync`, `in_vsync`, `in_hblnk`, `in_vblnk` in 1 each, timing flags.
- `in_rgb` in 12, background colour.
- `out_hcount` out 11, `out_vcount` out 11, delayed coordinates.
- `out_hsync`, `out_vsync`, `out_hblnk`, `out_vblnk` out 1 each, delayed timing flags.
- `out_rgb` out 12, composited colour.

## Operation
- **Vblank edge detect.** `vblnk_d` is `in_vblnk` registered. A frame edge (`fe`) is `in_vblnk & ~vblnk_d`.
- **Position latch.** On `fe`, latch `xl = min(xpos_in, XPOS_MAX-15)` and `yl = min(ypos_in, YPOS_MAX-15)`.
  - Compare at 12 bits, unsigned.
  - Changes to `xpos_in`/`ypos_in` between edges are ignored.
- **Stage 1.** Register all `in_*` signals. Compute `dx = in_hcount - xl` and `dy = in_vcount - yl`, 12-bit, zero-extended.
  - `hit = (in_hcount >= xl) & (in_hcount < xl+16) & (in_vcount >= yl) & (in_vcount < yl+16)`.
  - Look up ROM row `dy[3:0]`.
- **Cursor shape ROM.** Row r (0..11) has MSB-first bits [15:15-r] set; rows 12..15 are zero.
  - Net effect: pixel is lit iff `0 <= dx <= dy <= 11`.
- **Stage 2.** `pix = hit & row[15-dx[3:0]] & visible & ~hblnk_s1 & ~vblnk_s1`.
  - `out_rgb = pix ? CURSOR_COLOR : rgb_s1`.
  - All other outputs are the stage-1 values registered once more.
- **Blanking.** Background RGB passes through unchanged during blanking; blanking of the background is upstream's responsibility.
- **Visibility.** `visible` is constant 1 unless `CURSOR_BLINK_EN` is defined.

## Timing
- **Latency.** Every output equals the corresponding input delayed exactly 2 `clk` cycles, with `out_rgb` overridden on cursor pixels.
- **Throughput.** One pixel per cycle; no stalls, no handshake.
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - All `out_*` = 0.
  - `xl`, `yl`, `vblnk_d`, blink counter = 0.
  - `visible` = 1.
- **Reset mid-frame.** Outputs drop to 0 at once.
  - After release, outputs track inputs 2 cycles later.
  - The cursor stays at (0,0) until the first `fe`.
- **Latch timing.** A position presented on the cycle of `fe` is latched and first drawn in the active area of the following frame.
- **Clamping boundary.**
  - `xpos_in = 784` → `xl = 784`.
  - `xpos_in = 785..4095` → `xl = 784`.
  - Same rule for Y with limit 584.
- **No wrap.** The cursor never wraps past the right or bottom edge.

## Configuration
- **`CURSOR_BLINK_EN` defined.**
  - A frame counter `fc` (width `$clog2(BLINK_FRAMES)`) increments on each `fe`.
  - On the `fe` where `fc == BLINK_FRAMES-1`, `fc` returns to 0 and `visible` toggles.
  - Result: the cursor is shown for `BLINK_FRAMES` frames, hidden for `BLINK_FRAMES`, and so on.
  - `visible` changes only on `fe`, never mid-frame.
- **`CURSOR_BLINK_EN` undefined.** No counter is built and `visible` is 1.

## Test plan
- **Reset.** Hold `rst_n = 0` with active inputs → all outputs 0. Release → after cycle 2, `out_hcount`/`out_vcount`/syncs equal the inputs of 2 cycles earlier.
- **Latency and pass-through.** Single-cycle `in_hsync` pulse at cycle n with `in_rgb = 12'h123` outside the cursor → `out_hsync` high exactly at n+2, `out_rgb = 12'h123`.
- **Shape.** Latch `xpos_in = 100`, `ypos_in = 50`; next frame check:
  - (100,50) → 12'hFFF.
  - (101,50) → background.
  - (105,60) → 12'hFFF.
  - (112,61) → background.
  - (100,62) → background.
- **Clamp.** `xpos_in = 2000`, `ypos_in = 4000` → next frame (784,584) = 12'hFFF and (783,584) = background.
- **Mid-frame change.** Move `xpos_in` 100→300 at vcount 200 → the cursor stays at x=100 for the rest of the frame and is at x=300 in the next frame.
- **Blink (`CURSOR_BLINK_EN`, `BLINK_FRAMES = 2`).** Constant position → cursor drawn in frames 1–2, absent in 3–4, drawn in 5–6.
